downcounter: RTL and testbench
==============================

DOWNCOUNTER -- requirements
Module: downcounter

Interface
REQ-001 Parameter: WIDTH, 4, counter and load-value width in bits (legal range 2..16).
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  reset, synchronous and active-low; sampled on rising edge of clk.
REQ-004 Port: load  input  1  load strobe; captures load_val.
REQ-005 Port: load_val  input  WIDTH  start and reload value.
REQ-006 Port: en  input  1  count enable; one decrement per enabled cycle.
REQ-007 Port: reload  input  1  mode select: 1 = auto-reload, 0 = one-shot; sampled at terminal event.
REQ-008 Port: counter  output  WIDTH  current count, registered.
REQ-009 Port: tc  output  1  terminal-count pulse, registered.
REQ-010 Port: busy  output  1  high while in RUN.
REQ-011 Port: done  output  1  high while in DONE.

Function
REQ-012 State machine SHALL have three states: IDLE, RUN, DONE; busy = (state==RUN), done = (state==DONE), both registered or decoded from the state register only.
REQ-013 Priority per edge SHALL be: reset low > load > en; en SHALL have no effect outside RUN.
REQ-014 load with load_val!=0, in any state: counter <= load_val, reload register <= load_val, state <= RUN, tc <= 0.
REQ-015 load with load_val==0, in any state: counter <= 0, reload register <= 0, state <= IDLE, tc <= 0.
REQ-016 RUN, en=0, no load: counter, state and reload register SHALL hold; tc <= 0.
REQ-017 RUN, en=1, counter>1, no load: counter <= counter-1; tc <= 0.
REQ-018 RUN, en=1, counter==1, reload=1, no load (terminal, auto-reload): counter <= reload register, tc <= 1, state stays RUN.
REQ-019 RUN, en=1, counter==1, reload=0, no load (terminal, one-shot): counter <= 0, tc <= 1, state <= DONE.
REQ-020 tc SHALL be high for exactly one cycle per terminal event, coincident with the cycle counter first shows 0 (one-shot) or the reloaded value (auto-reload); tc <= 0 on every other edge.
REQ-021 Period SHALL be exactly N enabled cycles per terminal event for load value N (1..2^WIDTH-1); counter SHALL never be 0 while in RUN and SHALL never underflow/wrap.
REQ-022 IDLE and DONE: counter holds (0), tc=0; exit only via load.
REQ-023 load coinciding with a terminal condition: load wins, no tc pulse, new count starts.
REQ-024 load_val and reload SHALL be consumed only as stated; changes on other cycles have no effect on the running count.
REQ-025 Maximum load (all ones) SHALL count the full 2^WIDTH-1 enabled cycles.

Reset
REQ-026 reset low at a rising edge: state <= IDLE, counter <= 0, reload register <= 0, tc <= 0, busy = 0, done = 0, irrespective of load/en.
REQ-027 reset SHALL take effect only at a clock edge; no asynchronous path from reset to any register.
REQ-028 reset low mid-count SHALL abort the count with no tc pulse.

Verification
REQ-029 Hold reset low with load=1, load_val=5, en=1 for 3 cycles -> counter=0, tc=0, busy=0, done=0 throughout; release -> stays IDLE.
REQ-030 load_val=5, reload=0, en held 1 -> counter 5,4,3,2,1,0; tc=1 only on the 0 cycle; then done=1, busy=0, counter holds 0 for 10 more cycles.
REQ-031 load_val=3, reload=1, en held 1 for 7 cycles -> counter 3,2,1,3,2,1,3; tc high on both cycles showing the reloaded 3; busy stays 1.
REQ-032 load_val=4, en pattern 1,0,0,1,1,0,1 -> counter 4,3,3,3,2,1,1,0; tc single pulse at 0.
REQ-033 load_val=9 asserted on cycle counter==1 with en=1 -> next counter=9, tc=0, busy=1; then load_val=0 -> IDLE, counter=0, no tc.
REQ-034 WIDTH=4, load_val=15, reload=0, en held -> tc after exactly 15 enabled cycles; reset low at counter=7 -> next edge counter=0, IDLE, no tc.

Source files
------------

// File: rtl/downcounter_if.sv
// Control and status bundle for the down-counter: strobes/mode in, count and status out.
// load and en are single-cycle qualifiers sampled on each rising clk edge; there is no back-pressure.
interface downcounter_if #(
    parameter int WIDTH = 4
);
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             en;
    logic             reload;
    logic [WIDTH-1:0] counter;
    logic             tc;
    logic             busy;
    logic             done;
    logic [1:0]       dbg_state;

    modport master (
        output load, load_val, en, reload,
        input  counter, tc, busy, done, dbg_state
    );

    modport slave (
        input  load, load_val, en, reload,
        output counter, tc, busy, done, dbg_state
    );
endinterface

// File: rtl/downcounter.sv
// Loadable down-counter with one-shot / auto-reload modes and a registered terminal-count pulse.
// The running count never rests at 0 in RUN; reaching 1 with en is the terminal event.
module downcounter #(
    parameter int WIDTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    downcounter_if.slave  bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             tc_q, tc_d;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        tc_d     = 1'b0;
        if (bus.load) begin
            // A zero load parks the counter in IDLE rather than starting a zero-length run.
            count_d  = bus.load_val;
            reload_d = bus.load_val;
            state_d  = (bus.load_val != ZERO) ? RUN : IDLE;
        end else if (state_q == RUN && bus.en) begin
            if (count_q > ONE) begin
                count_d = count_q - ONE;
            end else begin
                tc_d = 1'b1;
                if (bus.reload) begin
                    count_d = reload_q;
                end else begin
                    count_d = ZERO;
                    state_d = DONE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            count_q  <= ZERO;
            reload_q <= ZERO;
            tc_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            tc_q     <= tc_d;
        end
    end

    assign bus.counter   = count_q;
    assign bus.tc        = tc_q;
    assign bus.busy      = (state_q == RUN);
    assign bus.done      = (state_q == DONE);
    assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_downcounter.sv
// Randomized and directed stimulus for downcounter, checked by a queue-based scoreboard
// against a period/elapsed-cycles reference model.
module tb_downcounter;
    localparam int W = 4;

    logic clk = 1'b0;
    logic reset;

    downcounter_if #(.WIDTH(W)) bus ();

    downcounter #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Expected {counter, tc, busy, done} after each edge.
    logic [W+2:0] exp_q[$];

    // Reference model: phase 0 idle, 1 running, 2 finished; period n, enabled cycles elapsed k.
    int m_phase = 0;
    int m_n     = 0;
    int m_k     = 0;
    bit m_tc    = 1'b0;

    task automatic step(input bit rst_n, input bit ld, input int lv, input bit e, input bit rl);
        logic [W-1:0] exp_cnt;
        @(negedge clk);
        reset        = rst_n;
        bus.load     = ld;
        bus.load_val = lv[W-1:0];
        bus.en       = e;
        bus.reload   = rl;
        m_tc = 1'b0;
        if (!rst_n) begin
            m_phase = 0;
            m_n     = 0;
            m_k     = 0;
        end else if (ld) begin
            m_n     = lv % (1 << W);
            m_k     = 0;
            m_phase = (m_n != 0) ? 1 : 0;
        end else if (m_phase == 1 && e) begin
            m_k = m_k + 1;
            if (m_k == m_n) begin
                m_tc = 1'b1;
                if (rl) m_k = 0;
                else m_phase = 2;
            end
        end
        exp_cnt = (m_phase == 1) ? W'(m_n - m_k) : '0;
        exp_q.push_back({exp_cnt, m_tc, m_phase == 1, m_phase == 2});
    endtask

    // Monitor: one DUT observation per edge, paired with the oldest expectation.
    initial begin
        logic [W+2:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks = checks + 4;
                if (bus.counter !== e[W+2:3]) begin
                    errors++;
                    $display("FAIL counter t=%0t got %0d expected %0d", $time, bus.counter, e[W+2:3]);
                end
                if (bus.tc !== e[2]) begin
                    errors++;
                    $display("FAIL tc t=%0t got %b expected %b", $time, bus.tc, e[2]);
                end
                if (bus.busy !== e[1]) begin
                    errors++;
                    $display("FAIL busy t=%0t got %b expected %b", $time, bus.busy, e[1]);
                end
                if (bus.done !== e[0]) begin
                    errors++;
                    $display("FAIL done t=%0t got %b expected %b", $time, bus.done, e[0]);
                end
            end
        end
    end

    initial begin
        int pat[7];
        pat = '{1, 0, 0, 1, 1, 0, 1};
        reset = 1'b0; bus.load = 1'b0; bus.load_val = '0; bus.en = 1'b0; bus.reload = 1'b0;

        // Reset dominates load/en, then release stays idle.
        for (int i = 0; i < 3; i++) step(0, 1, 5, 1, 0);
        for (int i = 0; i < 2; i++) step(1, 0, 0, 1, 0);

        // One-shot 5 then DONE for 10 cycles.
        step(1, 1, 5, 0, 0);
        for (int i = 0; i < 15; i++) step(1, 0, $urandom_range(0, 15), 1, 0);

        // Auto-reload 3 for 7 enabled cycles.
        step(1, 1, 3, 0, 1);
        for (int i = 0; i < 7; i++) step(1, 0, $urandom_range(0, 15), 1, 1);

        // Gapped enable pattern.
        step(1, 1, 4, 0, 0);
        for (int i = 0; i < 7; i++) step(1, 0, 0, pat[i][0], 0);
        step(1, 0, 0, 0, 0);

        // Load overriding a terminal condition, then zero load.
        step(1, 1, 9, 0, 0);
        for (int i = 0; i < 8; i++) step(1, 0, 0, 1, 0);
        step(1, 1, 9, 1, 0);
        step(1, 0, 0, 1, 0);
        step(1, 1, 0, 1, 0);
        step(1, 0, 0, 1, 0);

        // Full-range one-shot, then reset mid-count.
        step(1, 1, 15, 0, 0);
        for (int i = 0; i < 16; i++) step(1, 0, 0, 1, 0);
        step(1, 1, 15, 0, 0);
        for (int i = 0; i < 8; i++) step(1, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 1, 0);

        // Randomized traffic.
        for (int i = 0; i < 500; i++) begin
            step($urandom_range(0, 39) != 0,
                 $urandom_range(0, 11) == 0,
                 ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 15),
                 $urandom_range(0, 9) < 7,
                 $urandom_range(0, 1));
        end

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
